// File: rtl/dual_port_ram_bank_pkg.sv
// Shared constants for the dual-port RAM bank: hard-block geometry,
// read-during-write encodings and controller state encodings.
package dual_port_ram_bank_pkg;

   localparam int MEM_MAXADDR = 10;
   localparam int MEM_MAXDATA = 1;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/dualPortRam.sv
// Behavioural model of the 1-bit VPR dualPortRam hard block:
// read-first on both ports, registered outputs, no reset.
module dualPortRam
   import dual_port_ram_bank_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_MAXADDR,
   parameter int DATA_WIDTH = MEM_MAXDATA
) (
   input  logic                  clk,
   input  logic                  we1,
   input  logic                  we2,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [DATA_WIDTH-1:0] data2,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we1) mem[addr1] <= data1;
      if (we2) mem[addr2] <= data2;
      out1 <= mem[addr1];
      out2 <= mem[addr2];
   end

endmodule

// File: rtl/dual_port_ram_tile.sv
// One bank of the RAM: DATA_WIDTH one-bit hard blocks side by side,
// all sharing the tile address and write enables of each port.
module dual_port_ram_tile
   import dual_port_ram_bank_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_ADDR  = MEM_MAXADDR
) (
   input  logic                  clk,
   input  logic                  we1,
   input  logic                  we2,
   input  logic [TILE_ADDR-1:0]  addr1,
   input  logic [TILE_ADDR-1:0]  addr2,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [DATA_WIDTH-1:0] data2,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2
);

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      dualPortRam #(
         .ADDR_WIDTH (TILE_ADDR),
         .DATA_WIDTH (MEM_MAXDATA)
      ) u_bit (
         .clk   (clk),
         .we1   (we1),
         .we2   (we2),
         .addr1 (addr1),
         .addr2 (addr2),
         .data1 (data1[i]),
         .data2 (data2[i]),
         .out1  (out1[i]),
         .out2  (out2[i])
      );
   end

endmodule

// File: rtl/dual_port_ram_bank.sv
// True-dual-port RAM built from 1-bit hard-block tiles, with post-reset
// zero-fill, port-1-wins write collisions, selectable RDW and optional output register.
module dual_port_ram_bank
   import dual_port_ram_bank_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int TILE_ADDR      = MEM_MAXADDR,
   parameter int RDW_MODE       = RDW_READ_FIRST,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we1,
   input  logic                  we2,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [DATA_WIDTH-1:0] data2,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2,
   output logic                  ready,
   output logic                  collision,
   output state_t                state_dbg
);

   localparam int NB = (ADDR_WIDTH > TILE_ADDR) ? 2**(ADDR_WIDTH - TILE_ADDR) : 1;
   localparam logic [ADDR_WIDTH-1:0] CLR_STEP = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] CLR_ODD  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}} ^ CLR_ODD;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;

   // The clear sweep writes the even/odd address pair c, c+1 every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RST;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            ST_RST: begin
               clr_cnt <= '0;
               if (CLEAR_ON_RESET != 0) begin
                  state <= ST_CLEAR;
               end else begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end
            end
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + CLR_STEP;
               if (clr_cnt == CLR_LAST) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end
            end
            ST_RUN:  state <= ST_RUN;
            default: state <= ST_RST;
         endcase
      end
   end

   assign state_dbg = state;

   logic                  run, coll;
   logic                  e_we1, e_we2;
   logic [ADDR_WIDTH-1:0] e_addr1, e_addr2;
   logic [DATA_WIDTH-1:0] e_data1, e_data2;

   assign run  = (state == ST_RUN);
   assign coll = run & we1 & we2 & (addr1 == addr2);

   always_comb begin
      e_we1   = 1'b0;
      e_we2   = 1'b0;
      e_addr1 = addr1;
      e_addr2 = addr2;
      e_data1 = data1;
      e_data2 = data2;
      if (state == ST_CLEAR) begin
         e_we1   = 1'b1;
         e_we2   = 1'b1;
         e_addr1 = clr_cnt;
         e_addr2 = clr_cnt | CLR_ODD;
         e_data1 = '0;
         e_data2 = '0;
      end else if (run) begin
         e_we1 = we1;
         e_we2 = we2 & ~coll;
      end
   end

   // Write-first bypass: a port's own write wins, else the other port's write to its address.
   logic                  byp1, byp2;
   logic [DATA_WIDTH-1:0] bd1, bd2;

   always_comb begin
      byp1 = 1'b0;
      bd1  = e_data1;
      byp2 = 1'b0;
      bd2  = e_data2;
      if (e_we1) begin
         byp1 = 1'b1;
      end else if (e_we2 && (e_addr2 == e_addr1)) begin
         byp1 = 1'b1;
         bd1  = e_data2;
      end
      if (e_we2) begin
         byp2 = 1'b1;
      end else if (e_we1 && (e_addr1 == e_addr2)) begin
         byp2 = 1'b1;
         bd2  = e_data1;
      end
   end

   logic [DATA_WIDTH-1:0] t_out1 [NB];
   logic [DATA_WIDTH-1:0] t_out2 [NB];
   logic [DATA_WIDTH-1:0] raw1, raw2;
   logic [TILE_ADDR-1:0]  t_addr1, t_addr2;
   logic [NB-1:0]         bank_we1, bank_we2;

   if (ADDR_WIDTH > TILE_ADDR) begin : g_split
      localparam int BW = ADDR_WIDTH - TILE_ADDR;
      logic [BW-1:0] bsel1, bsel2, bsel1_q, bsel2_q;

      assign bsel1   = e_addr1[ADDR_WIDTH-1:TILE_ADDR];
      assign bsel2   = e_addr2[ADDR_WIDTH-1:TILE_ADDR];
      assign t_addr1 = e_addr1[TILE_ADDR-1:0];
      assign t_addr2 = e_addr2[TILE_ADDR-1:0];

      always_ff @(posedge clk) begin
         if (reset) begin
            bsel1_q <= '0;
            bsel2_q <= '0;
         end else begin
            bsel1_q <= bsel1;
            bsel2_q <= bsel2;
         end
      end

      for (genvar b = 0; b < NB; b++) begin : g_we
         assign bank_we1[b] = e_we1 && (bsel1 == BW'(b));
         assign bank_we2[b] = e_we2 && (bsel2 == BW'(b));
      end

      assign raw1 = t_out1[bsel1_q];
      assign raw2 = t_out2[bsel2_q];
   end else begin : g_single
      assign t_addr1  = TILE_ADDR'(e_addr1);
      assign t_addr2  = TILE_ADDR'(e_addr2);
      assign bank_we1 = e_we1;
      assign bank_we2 = e_we2;
      assign raw1     = t_out1[0];
      assign raw2     = t_out2[0];
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      dual_port_ram_tile #(
         .DATA_WIDTH (DATA_WIDTH),
         .TILE_ADDR  (TILE_ADDR)
      ) u_tile (
         .clk   (clk),
         .we1   (bank_we1[b]),
         .we2   (bank_we2[b]),
         .addr1 (t_addr1),
         .addr2 (t_addr2),
         .data1 (e_data1),
         .data2 (e_data2),
         .out1  (t_out1[b]),
         .out2  (t_out2[b])
      );
   end

   logic                  run_q, coll_q, byp1_q, byp2_q;
   logic [DATA_WIDTH-1:0] bd1_q, bd2_q, rd1, rd2;

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q  <= 1'b0;
         coll_q <= 1'b0;
         byp1_q <= 1'b0;
         byp2_q <= 1'b0;
         bd1_q  <= '0;
         bd2_q  <= '0;
      end else begin
         run_q  <= run;
         coll_q <= coll;
         byp1_q <= (RDW_MODE == RDW_WRITE_FIRST) && run && byp1;
         byp2_q <= (RDW_MODE == RDW_WRITE_FIRST) && run && byp2;
         bd1_q  <= bd1;
         bd2_q  <= bd2;
      end
   end

   // Hard-block outputs are meaningless for non-RUN accesses, so force zero.
   assign rd1 = !run_q ? '0 : (byp1_q ? bd1_q : raw1);
   assign rd2 = !run_q ? '0 : (byp2_q ? bd2_q : raw2);

   if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk) begin
         if (reset) begin
            out1      <= '0;
            out2      <= '0;
            collision <= 1'b0;
         end else begin
            out1      <= rd1;
            out2      <= rd2;
            collision <= coll_q;
         end
      end
   end else begin : g_noreg
      assign out1      = rd1;
      assign out2      = rd2;
      assign collision = coll_q;
   end

endmodule

// File: tb/tb_dual_port_ram_bank.sv
// Directed bench for dual_port_ram_bank: three configurations share one stimulus
// bus (4-bit read-first with clear, 12-bit write-first with clear, 4-bit write-first registered).
module tb_dual_port_ram_bank;
   import dual_port_ram_bank_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        we1, we2;
   logic [11:0] addr1, addr2;
   logic [7:0]  data1, data2;

   logic [7:0]  out1_a, out2_a, out1_b, out2_b, out1_c, out2_c;
   logic        ready_a, ready_b, ready_c;
   logic        coll_a, coll_b, coll_c;
   state_t      st_a, st_b, st_c;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   dual_port_ram_bank #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .TILE_ADDR(10),
      .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .reset(reset), .we1(we1), .we2(we2),
      .addr1(addr1[3:0]), .addr2(addr2[3:0]), .data1(data1), .data2(data2),
      .out1(out1_a), .out2(out2_a), .ready(ready_a), .collision(coll_a), .state_dbg(st_a)
   );

   dual_port_ram_bank #(
      .ADDR_WIDTH(12), .DATA_WIDTH(8), .TILE_ADDR(10),
      .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .reset(reset), .we1(we1), .we2(we2),
      .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
      .out1(out1_b), .out2(out2_b), .ready(ready_b), .collision(coll_b), .state_dbg(st_b)
   );

   dual_port_ram_bank #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .TILE_ADDR(10),
      .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(0)
   ) dut_c (
      .clk(clk), .reset(reset), .we1(we1), .we2(we2),
      .addr1(addr1[3:0]), .addr2(addr2[3:0]), .data1(data1), .data2(data2),
      .out1(out1_c), .out2(out2_c), .ready(ready_c), .collision(coll_c), .state_dbg(st_c)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic w1, input logic [11:0] a1, input logic [7:0] d1,
                        input logic w2, input logic [11:0] a2, input logic [7:0] d2);
      we1 = w1; addr1 = a1; data1 = d1;
      we2 = w2; addr2 = a2; data2 = d2;
   endtask

   // Fill all 16 words of the 4-bit configurations with 0xE0 | address.
   task automatic preload_garbage();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 12'(2*i), 8'hE0 | 8'(2*i), 1'b1, 12'(2*i+1), 8'hE0 | 8'(2*i+1));
         tick();
      end
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
   endtask

   // Reset has just been released at this negedge; follow the 8-cycle clear of dut_a.
   task automatic test_clear_timing(input string tag);
      for (int k = 1; k <= 9; k++) begin
         tick();
         vectors++;
         if (ready_a !== (k == 9)) begin
            errors++;
            $display("FAIL %s_ready_a k=%0d: got %b want %b", tag, k, ready_a, (k == 9));
         end
         if (k < 9) begin
            vectors++;
            if ({out1_a, out2_a} !== 16'h0000) begin
               errors++;
               $display("FAIL %s_out_during_clear k=%0d: got %h want 0000", tag, k, {out1_a, out2_a});
            end
         end
         if (k == 1) begin
            vectors++;
            if (ready_c !== 1'b1) begin
               errors++;
               $display("FAIL %s_ready_c_no_clear: got %b want 1", tag, ready_c);
            end
            vectors++;
            if (st_a !== ST_CLEAR) begin
               errors++;
               $display("FAIL %s_state_a: got %0d want %0d", tag, st_a, ST_CLEAR);
            end
         end
      end
   endtask

   task automatic test_read_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 12'(i), 8'h00, 1'b0, 12'(15 - i), 8'h00);
         tick();
         vectors++;
         if ({out1_a, out2_a} !== 16'h0000) begin
            errors++;
            $display("FAIL %s_zero addr=%0d: got %h want 0000", tag, i, {out1_a, out2_a});
         end
      end
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
      repeat (3) tick();
      vectors++;
      if ({out1_a, out2_a, out1_b, out2_b, out1_c, out2_c} !== 48'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {out1_a, out2_a, out1_b, out2_b, out1_c, out2_c});
      end
      vectors++;
      if ({ready_a, ready_b, ready_c, coll_a, coll_b, coll_c} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000000", {ready_a, ready_b, ready_c, coll_a, coll_b, coll_c});
      end
      vectors++;
      if (st_a !== ST_RST || st_c !== ST_RST) begin
         errors++;
         $display("FAIL reset_state: got %0d/%0d want %0d", st_a, st_c, ST_RST);
      end
      reset = 1'b0;
      test_clear_timing("powerup");
   endtask

   task automatic test_clear();
      preload_garbage();
      drive(1'b0, 12'h003, 8'h00, 1'b0, 12'h00C, 8'h00);
      tick();
      vectors++;
      if ({out1_a, out2_a} !== 16'hE3EC) begin
         errors++;
         $display("FAIL preload_readback: got %h want e3ec", {out1_a, out2_a});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      test_clear_timing("clear");
      test_read_all_zero("clear");
   endtask

   task automatic test_reset_mid_clear();
      preload_garbage();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      vectors++;
      if (ready_a !== 1'b0 || st_a !== ST_RST) begin
         errors++;
         $display("FAIL midclear_abort: got ready=%b state=%0d want ready=0 state=%0d", ready_a, st_a, ST_RST);
      end
      reset = 1'b0;
      test_clear_timing("midclear");
      test_read_all_zero("midclear");
   endtask

   task automatic test_split();
      int k;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (k = 1; k <= 2200; k++) begin
         tick();
         if (ready_b === 1'b1) break;
      end
      vectors++;
      if (k != 2049) begin
         errors++;
         $display("FAIL split_clear_len: got ready after %0d cycles want 2049", k);
      end
      drive(1'b1, 12'h000, 8'hA5, 1'b1, 12'h400, 8'h5A);
      tick();
      vectors++;
      if ({coll_b, coll_a} !== 2'b01) begin
         errors++;
         $display("FAIL split_collision_flags: got b=%b a=%b want b=0 a=1", coll_b, coll_a);
      end
      vectors++;
      if ({out1_b, out2_b} !== 16'hA55A) begin
         errors++;
         $display("FAIL split_write_first: got %h want a55a", {out1_b, out2_b});
      end
      drive(1'b1, 12'hC00, 8'h3C, 1'b0, 12'h000, 8'h00);
      tick();
      vectors++;
      if (out1_b !== 8'h3C) begin
         errors++;
         $display("FAIL split_bank3_bypass: got %h want 3c", out1_b);
      end
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h400, 8'h00);
      tick();
      vectors++;
      if ({out1_b, out2_b} !== 16'hA55A) begin
         errors++;
         $display("FAIL split_read_bank0_1: got %h want a55a", {out1_b, out2_b});
      end
      drive(1'b0, 12'hC00, 8'h00, 1'b0, 12'h800, 8'h00);
      tick();
      vectors++;
      if ({out1_b, out2_b} !== 16'h3C00) begin
         errors++;
         $display("FAIL split_read_bank3_2: got %h want 3c00", {out1_b, out2_b});
      end
      vectors++;
      if ({out1_a, out2_a} !== 16'h3C3C) begin
         errors++;
         $display("FAIL split_alias_small: got %h want 3c3c", {out1_a, out2_a});
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 12'h005, 8'h11, 1'b1, 12'h005, 8'h22);
      tick();
      vectors++;
      if ({coll_a, coll_b} !== 2'b11) begin
         errors++;
         $display("FAIL coll_flag: got a=%b b=%b want 1/1", coll_a, coll_b);
      end
      vectors++;
      if ({out1_a, out2_a} !== 16'h0000) begin
         errors++;
         $display("FAIL coll_read_first: got %h want 0000", {out1_a, out2_a});
      end
      vectors++;
      if ({out1_b, out2_b} !== 16'h1111) begin
         errors++;
         $display("FAIL coll_write_first: got %h want 1111", {out1_b, out2_b});
      end
      drive(1'b0, 12'h005, 8'h00, 1'b0, 12'h005, 8'h00);
      tick();
      vectors++;
      if ({out1_a, out2_a, out1_b} !== 24'h111111 || coll_a !== 1'b0) begin
         errors++;
         $display("FAIL coll_readback: got %h coll=%b want 111111 coll=0", {out1_a, out2_a, out1_b}, coll_a);
      end
      vectors++;
      if (coll_c !== 1'b1 || {out1_c, out2_c} !== 16'h1111) begin
         errors++;
         $display("FAIL coll_oreg: got coll=%b data=%h want coll=1 data=1111", coll_c, {out1_c, out2_c});
      end
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
      tick();
      vectors++;
      if (coll_c !== 1'b0 || out2_c !== 8'h11) begin
         errors++;
         $display("FAIL coll_oreg_next: got coll=%b data=%h want coll=0 data=11", coll_c, out2_c);
      end
   endtask

   task automatic test_read_during_write();
      drive(1'b1, 12'h007, 8'h33, 1'b0, 12'h000, 8'h00);
      tick();
      drive(1'b1, 12'h007, 8'h44, 1'b0, 12'h007, 8'h00);
      tick();
      vectors++;
      if ({out1_a, out2_a} !== 16'h3333 || coll_a !== 1'b0) begin
         errors++;
         $display("FAIL rdw_p1w_read_first: got %h coll=%b want 3333 coll=0", {out1_a, out2_a}, coll_a);
      end
      vectors++;
      if ({out1_b, out2_b} !== 16'h4444) begin
         errors++;
         $display("FAIL rdw_p1w_write_first: got %h want 4444", {out1_b, out2_b});
      end
      drive(1'b0, 12'h007, 8'h00, 1'b1, 12'h007, 8'h55);
      tick();
      vectors++;
      if ({out1_a, out2_a} !== 16'h4444) begin
         errors++;
         $display("FAIL rdw_p2w_read_first: got %h want 4444", {out1_a, out2_a});
      end
      vectors++;
      if ({out1_b, out2_b} !== 16'h5555) begin
         errors++;
         $display("FAIL rdw_p2w_write_first: got %h want 5555", {out1_b, out2_b});
      end
      vectors++;
      if ({out1_c, out2_c} !== 16'h4444) begin
         errors++;
         $display("FAIL rdw_oreg_first: got %h want 4444", {out1_c, out2_c});
      end
      drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
      tick();
      vectors++;
      if (out1_c !== 8'h55) begin
         errors++;
         $display("FAIL rdw_oreg_second: got %h want 55", out1_c);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e1 [8];
      logic [7:0] e2 [8];
      e1 = '{8'h00, 8'hC2, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00};
      e2 = '{8'h00, 8'hC3, 8'hC3, 8'hC2, 8'hC1, 8'hC0, 8'h00, 8'h00};
      for (int n = 0; n < 8; n++) begin
         case (n)
            0:       drive(1'b1, 12'h000, 8'hC0, 1'b1, 12'h001, 8'hC1);
            1:       drive(1'b1, 12'h002, 8'hC2, 1'b1, 12'h003, 8'hC3);
            2, 3, 4, 5: drive(1'b0, 12'(n - 2), 8'h00, 1'b0, 12'(5 - n), 8'h00);
            default: drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00);
         endcase
         tick();
         if (n >= 2 && n <= 6) begin
            vectors++;
            if ({out1_c, out2_c} !== {e1[n-1], e2[n-1]}) begin
               errors++;
               $display("FAIL latency_stream n=%0d: got %h want %h", n, {out1_c, out2_c}, {e1[n-1], e2[n-1]});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_reset_mid_clear();
      test_split();
      test_collision();
      test_read_during_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
